// File: rtl/mem_wb_data_stage.sv
// ============================================================================
// Module   : mem_wb_data_stage
// Brief    : Registered MEM/WB lane select with a late-load wait FSM.
//            Define MEM_WB_LD_TIMEOUT_EN to add the load wait timeout.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_wb_data_stage #(
    parameter int DATA_W     = 8,
    parameter int LD_TIMEOUT = 15
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              in_valid,
    input  logic              ld_req,
    input  logic              sel_bot,
    input  logic [1:0]        sel_top,
    input  logic [DATA_W-1:0] sfr_data,
    input  logic [DATA_W-1:0] ex_mem_data_top,
    input  logic [DATA_W-1:0] ex_mem_data_bot,
    input  logic [DATA_W-1:0] ld_res_top,
    input  logic [DATA_W-1:0] ld_res_bot,
    input  logic              ld_valid,
    input  logic              flush,
    output logic              stall_out,
    output logic              out_valid,
    output logic [DATA_W-1:0] mem_data_out_top,
    output logic [DATA_W-1:0] mem_data_out_bot,
    output logic              ld_timeout_err
);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        WAIT_LD = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic              w_capture;
    logic              w_enter_wait;
    logic              w_stall;
    logic              w_timeout;

    logic [1:0]        r_sh_sel_top;
    logic              r_sh_sel_bot;
    logic [DATA_W-1:0] r_sh_ex_top;
    logic [DATA_W-1:0] r_sh_ex_bot;
    logic [DATA_W-1:0] r_sh_sfr;

    logic [1:0]        w_sel_top;
    logic              w_sel_bot;
    logic [DATA_W-1:0] w_ex_top;
    logic [DATA_W-1:0] w_ex_bot;
    logic [DATA_W-1:0] w_sfr;
    logic [DATA_W-1:0] w_ld_top;
    logic [DATA_W-1:0] w_ld_bot;
    logic [DATA_W-1:0] w_mux_top;
    logic [DATA_W-1:0] w_mux_bot;

`ifdef MEM_WB_LD_TIMEOUT_EN
    localparam int c_CNT_W = $clog2(LD_TIMEOUT + 1);

    logic [c_CNT_W-1:0] r_cnt;
    logic               r_ld_timeout_err;

    assign w_timeout = (r_state == WAIT_LD) && !ld_valid && !flush &&
                       (r_cnt == c_CNT_W'(LD_TIMEOUT - 1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt            <= '0;
            r_ld_timeout_err <= 1'b0;
        end else begin
            r_ld_timeout_err <= w_timeout;
            if (w_enter_wait || flush)
                r_cnt <= '0;
            else if (r_state == WAIT_LD && w_stall)
                r_cnt <= r_cnt + 1'b1;
        end
    end

    assign ld_timeout_err = r_ld_timeout_err;
`else
    logic w_unused_timeout;

    assign w_unused_timeout = (LD_TIMEOUT == 0);
    assign w_timeout        = 1'b0;
    assign ld_timeout_err   = 1'b0;
`endif

    always_comb begin
        w_next_state = r_state;
        w_capture    = 1'b0;
        w_enter_wait = 1'b0;
        w_stall      = 1'b0;
        case (r_state)
            IDLE: begin
                if (!flush && in_valid) begin
                    if (!ld_req || ld_valid) begin
                        w_capture = 1'b1;
                    end else begin
                        w_enter_wait = 1'b1;
                        w_stall      = 1'b1;
                        w_next_state = WAIT_LD;
                    end
                end
            end
            WAIT_LD: begin
                if (flush) begin
                    w_next_state = IDLE;
                end else if (ld_valid || w_timeout) begin
                    w_capture    = 1'b1;
                    w_next_state = IDLE;
                end else begin
                    w_stall = 1'b1;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // While waiting, selects and non-load data come from the shadow copy so
    // upstream may change EX/MEM freely; timeout substitutes zero load data.
    assign w_sel_top = (r_state == WAIT_LD) ? r_sh_sel_top : sel_top;
    assign w_sel_bot = (r_state == WAIT_LD) ? r_sh_sel_bot : sel_bot;
    assign w_ex_top  = (r_state == WAIT_LD) ? r_sh_ex_top  : ex_mem_data_top;
    assign w_ex_bot  = (r_state == WAIT_LD) ? r_sh_ex_bot  : ex_mem_data_bot;
    assign w_sfr     = (r_state == WAIT_LD) ? r_sh_sfr     : sfr_data;
    assign w_ld_top  = w_timeout ? '0 : ld_res_top;
    assign w_ld_bot  = w_timeout ? '0 : ld_res_bot;

    always_comb begin
        w_mux_top = '0;
        case (w_sel_top)
            2'b00:   w_mux_top = '0;
            2'b01:   w_mux_top = w_sfr;
            2'b10:   w_mux_top = w_ex_top;
            default: w_mux_top = w_ld_top;
        endcase
        w_mux_bot = w_sel_bot ? w_ld_bot : w_ex_bot;
    end

    assign stall_out = w_stall;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state          <= IDLE;
            out_valid        <= 1'b0;
            mem_data_out_top <= '0;
            mem_data_out_bot <= '0;
            r_sh_sel_top     <= 2'b00;
            r_sh_sel_bot     <= 1'b0;
            r_sh_ex_top      <= '0;
            r_sh_ex_bot      <= '0;
            r_sh_sfr         <= '0;
        end else begin
            r_state   <= w_next_state;
            out_valid <= w_capture;
            if (w_capture) begin
                mem_data_out_top <= w_mux_top;
                mem_data_out_bot <= w_mux_bot;
            end
            if (w_enter_wait) begin
                r_sh_sel_top <= sel_top;
                r_sh_sel_bot <= sel_bot;
                r_sh_ex_top  <= ex_mem_data_top;
                r_sh_ex_bot  <= ex_mem_data_bot;
                r_sh_sfr     <= sfr_data;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_wb_data_stage.sv
// ============================================================================
// Module   : tb_mem_wb_data_stage
// Brief    : Scoreboard bench for mem_wb_data_stage (LD_TIMEOUT = 4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_wb_data_stage;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       in_valid, ld_req, sel_bot, ld_valid, flush;
    logic [1:0] sel_top;
    logic [7:0] sfr_data, ex_mem_data_top, ex_mem_data_bot, ld_res_top, ld_res_bot;
    logic       stall_out, out_valid, ld_timeout_err;
    logic [7:0] mem_data_out_top, mem_data_out_bot;

    typedef struct packed {
        logic [7:0] top;
        logic [7:0] bot;
        logic       err;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;

    mem_wb_data_stage #(.DATA_W(8), .LD_TIMEOUT(4)) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .in_valid         (in_valid),
        .ld_req           (ld_req),
        .sel_bot          (sel_bot),
        .sel_top          (sel_top),
        .sfr_data         (sfr_data),
        .ex_mem_data_top  (ex_mem_data_top),
        .ex_mem_data_bot  (ex_mem_data_bot),
        .ld_res_top       (ld_res_top),
        .ld_res_bot       (ld_res_bot),
        .ld_valid         (ld_valid),
        .flush            (flush),
        .stall_out        (stall_out),
        .out_valid        (out_valid),
        .mem_data_out_top (mem_data_out_top),
        .mem_data_out_bot (mem_data_out_bot),
        .ld_timeout_err   (ld_timeout_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [7:0] t, input logic [7:0] b, input logic e);
        exp_t x;
        x.top = t;
        x.bot = b;
        x.err = e;
        q.push_back(x);
    endtask

    // One cycle: check combinational stall mid-cycle, then advance past the edge.
    task automatic tick(input logic exp_stall, input string name);
        @(negedge clock);
        check(name, stall_out, exp_stall);
        @(posedge clock);
        #1;
    endtask

    task automatic clr();
        in_valid = 1'b0;
        ld_req   = 1'b0;
        ld_valid = 1'b0;
        flush    = 1'b0;
    endtask

    // Monitor: every presented output must match the oldest expectation.
    always @(negedge clock) begin
        exp_t e;
        if (reset_n === 1'b1) begin
            if (out_valid) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: got out_valid=1 top=0x%0h bot=0x%0h expected no output",
                             mem_data_out_top, mem_data_out_bot);
                end else begin
                    e = q.pop_front();
                    check("out_top", mem_data_out_top, e.top);
                    check("out_bot", mem_data_out_bot, e.bot);
                    check("out_err", ld_timeout_err, e.err);
                end
            end else begin
                check("err_without_valid", ld_timeout_err, 1'b0);
            end
        end
    end

    initial begin
        reset_n = 1'b0;
        clr();
        sel_top = 2'b00; sel_bot = 1'b0;
        sfr_data = 8'h00; ex_mem_data_top = 8'h00; ex_mem_data_bot = 8'h00;
        ld_res_top = 8'h00; ld_res_bot = 8'h00;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_top", mem_data_out_top, 8'h00);
        check("rst_bot", mem_data_out_bot, 8'h00);
        check("rst_err", ld_timeout_err, 1'b0);
        check("rst_stall", stall_out, 1'b0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        tick(1'b0, "stall_idle");

        // Plain EX/MEM, then SFR and zero selects back-to-back
        in_valid = 1'b1; sel_top = 2'b10; sel_bot = 1'b0;
        ex_mem_data_top = 8'hA5; ex_mem_data_bot = 8'h3C;
        push(8'hA5, 8'h3C, 1'b0); tick(1'b0, "stall_ex");
        sel_top = 2'b01; sfr_data = 8'h7E;
        push(8'h7E, 8'h3C, 1'b0); tick(1'b0, "stall_sfr");
        sel_top = 2'b00;
        push(8'h00, 8'h3C, 1'b0); tick(1'b0, "stall_zero");

        // Same-cycle load
        ld_req = 1'b1; ld_valid = 1'b1; sel_top = 2'b11; sel_bot = 1'b1;
        ld_res_top = 8'h12; ld_res_bot = 8'h34;
        push(8'h12, 8'h34, 1'b0); tick(1'b0, "stall_same_ld");

        // Stray ld_valid in IDLE is ignored
        clr(); ld_valid = 1'b1;
        tick(1'b0, "stall_stray_ldv");
        clr();

        // Late load, k = 3; EX/MEM and selects change while waiting
        in_valid = 1'b1; ld_req = 1'b1; sel_top = 2'b10; sel_bot = 1'b1;
        ex_mem_data_top = 8'h55; ex_mem_data_bot = 8'h77;
        ld_res_top = 8'hEE; ld_res_bot = 8'hEE;
        tick(1'b1, "stall_late_0");
        ex_mem_data_top = 8'hFF; sel_top = 2'b00; sel_bot = 1'b0;
        tick(1'b1, "stall_late_1");
        tick(1'b1, "stall_late_2");
        ld_valid = 1'b1; ld_res_top = 8'hAA; ld_res_bot = 8'h99;
        push(8'h55, 8'h99, 1'b0); tick(1'b0, "stall_late_cap");
        clr();

        // Flush during WAIT_LD
        in_valid = 1'b1; sel_top = 2'b10; sel_bot = 1'b0;
        ex_mem_data_top = 8'h11; ex_mem_data_bot = 8'h22;
        push(8'h11, 8'h22, 1'b0); tick(1'b0, "stall_pre_flush");
        ld_req = 1'b1; sel_bot = 1'b1; ex_mem_data_top = 8'h33; ex_mem_data_bot = 8'h44;
        tick(1'b1, "stall_fl_0");
        tick(1'b1, "stall_fl_1");
        flush = 1'b1;
        tick(1'b0, "stall_flush");
        flush = 1'b0; ld_req = 1'b0; in_valid = 1'b1; sel_top = 2'b10; sel_bot = 1'b0;
        ex_mem_data_top = 8'h66; ex_mem_data_bot = 8'h88;
        push(8'h66, 8'h88, 1'b0);
        @(negedge clock);
        check("flush_out_valid", out_valid, 1'b0);
        check("flush_top_hold", mem_data_out_top, 8'h11);
        check("flush_bot_hold", mem_data_out_bot, 8'h22);
        check("flush_idle_stall", stall_out, 1'b0);
        @(posedge clock); #1;
        clr();

        // Load never arrives (timeout) / arrives very late (no timeout)
        in_valid = 1'b1; ld_req = 1'b1; sel_top = 2'b11; sel_bot = 1'b1;
        ld_res_top = 8'h5A; ld_res_bot = 8'h5B;
`ifdef MEM_WB_LD_TIMEOUT_EN
        for (int i = 0; i < 4; i++) tick(1'b1, "stall_to_wait");
        push(8'h00, 8'h00, 1'b1); tick(1'b0, "stall_timeout");
`else
        for (int i = 0; i < 6; i++) tick(1'b1, "stall_long_wait");
        ld_valid = 1'b1;
        push(8'h5A, 8'h5B, 1'b0); tick(1'b0, "stall_long_cap");
`endif
        clr();

        // Mid-stream reset while in WAIT_LD
        in_valid = 1'b1; sel_top = 2'b10; sel_bot = 1'b0;
        ex_mem_data_top = 8'hC3; ex_mem_data_bot = 8'h3D;
        push(8'hC3, 8'h3D, 1'b0); tick(1'b0, "stall_pre_rst");
        ld_req = 1'b1;
        tick(1'b1, "stall_rst_0");
        tick(1'b1, "stall_rst_1");
        clr();
        reset_n = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid, 1'b0);
        check("mid_rst_top", mem_data_out_top, 8'h00);
        check("mid_rst_bot", mem_data_out_bot, 8'h00);
        check("mid_rst_err", ld_timeout_err, 1'b0);
        check("mid_rst_state_idle", stall_out, 1'b0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        tick(1'b0, "stall_post_rst");
        tick(1'b0, "stall_post_rst");

        check("scoreboard_empty", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_wb_data_stage.md
# mem_wb_data_stage

Registered, parametrised MEM/WB data-select stage. It sits between the EX/MEM register and the WB stage. Each cycle it chooses the top and bottom result lanes from the SFR, EX/MEM and load-result sources. Loads that return late are absorbed by a wait state machine, which stalls the upstream pipeline until the data arrives or an optional timeout fires.

## Interface
Parameters:
- DATA_W, 8, width of each lane (top and bottom).
- LD_TIMEOUT, 15, maximum cycles spent in WAIT_LD (≥2); used only when the timeout feature is compiled in.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  EX/MEM holds a valid instruction this cycle.
- ld_req  in  1  instruction needs load-result data; qualified by in_valid.
- sel_bot  in  1  bottom source: 0 = ex_mem_data_bot, 1 = ld_res_bot.
- sel_top  in  2  top source: 00 = zero, 01 = sfr_data, 10 = ex_mem_data_top, 11 = ld_res_top.
- sfr_data  in  DATA_W  SFR read data.
- ex_mem_data_top, ex_mem_data_bot  in  DATA_W  EX/MEM result lanes.
- ld_res_top, ld_res_bot  in  DATA_W  data-memory load result lanes.
- ld_valid  in  1  load result valid this cycle.
- flush  in  1  kill the current instruction.
- stall_out  out  1  combinational; upstream must hold EX/MEM while high.
- out_valid  out  1  registered; MEM/WB data valid.
- mem_data_out_top, mem_data_out_bot  out  DATA_W  registered MEM/WB data.
- ld_timeout_err  out  1  registered one-cycle pulse on load timeout.

## Operation
- States: IDLE, WAIT_LD. Reset puts the block in IDLE.
- Reset values: out_valid = 0, both data outputs = 0, ld_timeout_err = 0, wait counter = 0.
- IDLE, in_valid & !ld_req: capture the muxed lanes; out_valid = 1 next cycle.
- IDLE, in_valid & ld_req & ld_valid: capture directly, with ld_res lanes used where selected. No stall.
- IDLE, in_valid & ld_req & !ld_valid:
  - Latch sel_top, sel_bot, ex_mem_data_top/bot and sfr_data into shadow registers.
  - Go to WAIT_LD and clear the counter.
  - stall_out = 1 this cycle.
  - out_valid = 0 next cycle.
- WAIT_LD, ld_valid: capture using the shadow selects and data plus the live ld_res lanes. Go to IDLE; out_valid = 1 next cycle; stall_out = 0 this cycle.
- WAIT_LD, !ld_valid: stall_out = 1, counter increments, out_valid = 0.
- Cycles with no capture set out_valid = 0. Data outputs hold their last value.
- Lanes not selected from the load result ignore ld_res entirely.
- flush has highest priority in any state:
  - Next state is IDLE and the counter clears.
  - out_valid = 0 next cycle; data outputs hold.
  - stall_out = 0; no capture occurs.
  - ld_timeout_err is not raised.
- ld_valid while in IDLE with no load request is ignored.

## Timing
- Non-load latency: in_valid at edge N gives out_valid at N+1.
- Load latency: with ld_valid first seen in cycle N+k, out_valid is asserted at N+k+1. stall_out is high during cycles N to N+k-1.
- stall_out is combinational from in_valid, ld_req, ld_valid, flush and state. It is never high in the cycle that captures.
- Back-to-back non-load instructions produce out_valid on consecutive cycles.
- Counter width is $clog2(LD_TIMEOUT+1). It never wraps because the timeout exits first.
- Reset deassertion mid-WAIT_LD is not a concern; reset assertion forces IDLE immediately.

## Configuration
- MEM_WB_LD_TIMEOUT_EN defined:
  - In WAIT_LD, if the counter equals LD_TIMEOUT-1 and ld_valid is low, a timeout occurs that cycle.
  - On timeout, capture with the ld_res lanes replaced by zero; out_valid = 1 and ld_timeout_err = 1 next cycle; go to IDLE; stall_out = 0 that cycle.
  - WAIT_LD therefore lasts at most LD_TIMEOUT cycles.
- Undefined: no counter is built, WAIT_LD waits indefinitely, and ld_timeout_err is tied to 0.

## Test plan
- Reset: hold reset_n = 0 mid-stream → all outputs 0 and state IDLE. Release, then in_valid = 1, sel_top = 10, sel_bot = 0, ex_mem = 0xA5/0x3C → next cycle out_valid = 1, top = 0xA5, bot = 0x3C.
- SFR select: sel_top = 01, sfr_data = 0x7E → top = 0x7E. Then sel_top = 00 → top = 0x00.
- Same-cycle load: ld_req = 1, ld_valid = 1, sel_top = 11, sel_bot = 1, ld_res = 0x12/0x34 → stall_out never high, next-cycle output 0x12/0x34.
- Late load, k = 3:
  - Stimulus: sel_top = 10, sel_bot = 1, ex_mem_top = 0x55. After entry, change ex_mem_top to 0xFF.
  - Response: stall_out is high for 3 cycles. ld_valid with ld_res_bot = 0x99 gives output 0x55/0x99 one cycle later.
- Flush in WAIT_LD at cycle 2 → state IDLE, stall_out = 0, out_valid stays 0, data outputs unchanged.
- With MEM_WB_LD_TIMEOUT_EN and LD_TIMEOUT = 4, ld_valid never asserted → stall_out high for 4 cycles, then out_valid = 1, ld_timeout_err pulses once, and load lanes = 0x00.
